mrd_stage_sched: RTL and testbench
==================================

Name: mrd_stage_sched

Overview:
Top-level stage sequencer for the mixed-radix DFT engine with a single shared RAM. It accepts a frame through the sink, waits for the stage parameters to settle, then runs each factor stage as a read phase followed by a write phase. It then launches the source phase. It drives the memory top's state and current-stage inputs and provides per-phase start pulses, frame-protocol error flags and a watchdog.

Parameters:
PARAM_WAIT, 8, cycles held in PARAM after sink end so the parameter pipeline (quotient/remainder/twiddle denominators) settles; must be >= 1
TIMEOUT, 4096, maximum cycles allowed in any RD or WR phase before abort; 0 disables the watchdog
STG_W, 3, width of stage index and factor count

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sink_sop  in  1  first sample of input frame
sink_eop  in  1  last sample of input frame
num_factors  in  STG_W  number of factor stages for the current frame; sampled on the cycle sink_eop is accepted
source_ongoing  in  1  previous frame's source still draining the RAM
rd_done  in  1  one-cycle pulse: current stage read pass complete
wr_done  in  1  one-cycle pulse: current stage write-back complete
fsm  out  3  0 IDLE, 1 SINK, 2 PARAM, 3 RD, 4 WR, 5 SRC
current_stage  out  STG_W  stage index 0..num_factors-1
sink_ready  out  1  high in IDLE and SINK only
rd_start  out  1  one-cycle pulse on entry to RD
wr_start  out  1  one-cycle pulse on entry to WR
source_start  out  1  one-cycle pulse while in SRC
busy  out  1  fsm != IDLE
err_sop  out  1  one-cycle pulse: protocol violation on sink_sop/sink_eop
err_timeout  out  1  one-cycle pulse: watchdog abort

Behaviour:
- Reset (asynchronous, any state): fsm=IDLE, current_stage=0, nf_lat=0, wait/watchdog counters=0. All pulses are 0; sink_ready=1; busy=0. All outputs are registered.
- IDLE: on sink_sop, go to SINK next cycle. A sink_sop and sink_eop in the same cycle (1-sample frame) goes directly to PARAM and latches num_factors. A sink_eop without sink_sop is ignored and raises err_sop.
- SINK: on sink_eop, latch nf_lat=num_factors, clear wait_cnt and go to PARAM. A sink_sop in SINK raises err_sop; the frame continues and the sop is ignored.
- PARAM: wait_cnt increments each cycle, saturating at PARAM_WAIT. Leave when wait_cnt==PARAM_WAIT-1 (or later) and source_ongoing==0. PARAM therefore lasts at least PARAM_WAIT cycles and stretches while the source is still active.
  - If nf_lat==0, go to SRC.
  - Otherwise set current_stage=0 and go to RD.
- RD: rd_start=1 on the first RD cycle only. rd_done moves to WR next cycle. An rd_done coincident with rd_start is accepted.
- WR: wr_start=1 on the first WR cycle. On wr_done:
  - if current_stage==nf_lat-1, go to SRC;
  - otherwise increment current_stage and go to RD. current_stage changes on the same edge as the transition.
- SRC: source_start=1 for exactly one cycle, then IDLE. current_stage holds its last value until the next PARAM exit.
- sink_sop/sink_eop in PARAM, RD, WR or SRC: ignored, err_sop pulses. Incoming data is dropped upstream (sink_ready=0).
- rd_done in a state other than RD, or wr_done in a state other than WR: ignored, no error.
- Watchdog: the counter clears on RD/WR entry and increments each cycle in RD/WR. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without the corresponding done, err_timeout pulses and fsm returns to IDLE next cycle with current_stage=0.
- Width: current_stage increment never wraps, because nf_lat <= 2^STG_W-1 bounds it.

Test Plan:
1. 1200-pt frame, nf=5, PARAM_WAIT=8, source idle. sop at t0, eop at t1199 → PARAM for 8 cycles, then RD/WR x5 with current_stage 0..4. Exactly 5 rd_start and 5 wr_start pulses, one source_start, then IDLE.
2. Same frame with source_ongoing held high 20 cycles past PARAM_WAIT → RD entry delayed until the cycle after source_ongoing falls; no pulses during the stall.
3. nf=0 → PARAM → SRC → IDLE; no rd_start or wr_start.
4. rd_done never asserted, TIMEOUT=64 → err_timeout pulse on RD cycle 64, fsm=0 next cycle, current_stage=0; a following normal frame completes correctly.
5. Second sink_sop during SINK, and sink_sop during WR → err_sop pulses in each case; stage sequence and stage count unchanged.
6. rst asserted mid-WR at stage 2 → outputs at reset values immediately (asynchronous), without waiting for a clock edge; after release, fsm=IDLE and sink_ready=1.

Source files
------------

// File: rtl/mrd_stage_sched_if.sv
// Handshake bundle between the mixed-radix DFT stage sequencer and its surroundings.
// The master side is the sequencer. The slave side is the sink/memory/source environment.
interface mrd_stage_sched_if #(
  parameter int STG_W = 3
) ();
  logic             sink_sop;
  logic             sink_eop;
  logic [STG_W-1:0] num_factors;
  logic             source_ongoing;
  logic             rd_done;
  logic             wr_done;
  logic [2:0]       fsm;
  logic [STG_W-1:0] current_stage;
  logic             sink_ready;
  logic             rd_start;
  logic             wr_start;
  logic             source_start;
  logic             busy;
  logic             err_sop;
  logic             err_timeout;

  modport master (
    input  sink_sop, sink_eop, num_factors, source_ongoing, rd_done, wr_done,
    output fsm, current_stage, sink_ready, rd_start, wr_start, source_start,
           busy, err_sop, err_timeout
  );

  modport slave (
    output sink_sop, sink_eop, num_factors, source_ongoing, rd_done, wr_done,
    input  fsm, current_stage, sink_ready, rd_start, wr_start, source_start,
           busy, err_sop, err_timeout
  );
endinterface

// File: rtl/mrd_stage_sched.sv
// Stage sequencer for the single-RAM mixed-radix DFT engine.
// Flow: sink -> parameter settle -> (read, write) per factor -> source. All outputs are registered.
module mrd_stage_sched #(
  parameter int PARAM_WAIT = 8,
  parameter int TIMEOUT    = 4096,
  parameter int STG_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  mrd_stage_sched_if.master  bus
);

  localparam int WAIT_W = $clog2(PARAM_WAIT + 1);
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SINK  = 3'd1,
    S_PARAM = 3'd2,
    S_RD    = 3'd3,
    S_WR    = 3'd4,
    S_SRC   = 3'd5
  } state_t;

  state_t            fsm_q, fsm_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [STG_W-1:0]  nf_q, nf_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              sink_ready_q, sink_ready_d;
  logic              rd_start_q, rd_start_d;
  logic              wr_start_q, wr_start_d;
  logic              src_start_q, src_start_d;
  logic              busy_q, busy_d;
  logic              err_sop_q, err_sop_d;
  logic              err_to_q, err_to_d;

  always_comb begin
    fsm_d     = fsm_q;
    stage_d   = stage_q;
    nf_d      = nf_q;
    wait_d    = wait_q;
    wd_d      = wd_q;
    err_sop_d = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (bus.sink_sop) begin
          if (bus.sink_eop) begin
            nf_d   = bus.num_factors;
            wait_d = '0;
            fsm_d  = S_PARAM;
          end else begin
            fsm_d  = S_SINK;
          end
        end else if (bus.sink_eop) begin
          err_sop_d = 1'b1;
        end
      end
      S_SINK: begin
        err_sop_d = bus.sink_sop;
        if (bus.sink_eop) begin
          nf_d   = bus.num_factors;
          wait_d = '0;
          fsm_d  = S_PARAM;
        end
      end
      S_PARAM: begin
        err_sop_d = bus.sink_sop | bus.sink_eop;
        if (wait_q != WAIT_W'(PARAM_WAIT)) wait_d = wait_q + WAIT_W'(1);
        // Parameter pipeline must settle and the previous frame must have left the RAM.
        if ((wait_q >= WAIT_W'(PARAM_WAIT - 1)) && !bus.source_ongoing) begin
          if (nf_q == '0) begin
            fsm_d = S_SRC;
          end else begin
            stage_d = '0;
            fsm_d   = S_RD;
          end
        end
      end
      S_RD: begin
        err_sop_d = bus.sink_sop | bus.sink_eop;
        if (err_to_q) begin
          stage_d = '0;
          fsm_d   = S_IDLE;
        end else if (bus.rd_done) begin
          fsm_d = S_WR;
        end
      end
      S_WR: begin
        err_sop_d = bus.sink_sop | bus.sink_eop;
        if (err_to_q) begin
          stage_d = '0;
          fsm_d   = S_IDLE;
        end else if (bus.wr_done) begin
          if (stage_q == nf_q - STG_W'(1)) begin
            fsm_d = S_SRC;
          end else begin
            stage_d = stage_q + STG_W'(1);
            fsm_d   = S_RD;
          end
        end
      end
      S_SRC: begin
        err_sop_d = bus.sink_sop | bus.sink_eop;
        fsm_d     = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase

    // Watchdog restarts on every RD/WR entry. The abort flag is raised one cycle ahead so it is
    // visible on the last phase cycle before the return to IDLE.
    if ((fsm_d == S_RD) || (fsm_d == S_WR)) begin
      if (fsm_d != fsm_q)     wd_d = '0;
      else if (TIMEOUT != 0)  wd_d = wd_q + WD_W'(1);
    end
    err_to_d = (TIMEOUT != 0) && ((fsm_d == S_RD) || (fsm_d == S_WR)) &&
               (wd_d == WD_W'(TIMEOUT - 1));

    rd_start_d   = (fsm_d == S_RD) && (fsm_q != S_RD);
    wr_start_d   = (fsm_d == S_WR) && (fsm_q != S_WR);
    src_start_d  = (fsm_d == S_SRC);
    sink_ready_d = (fsm_d == S_IDLE) || (fsm_d == S_SINK);
    busy_d       = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      stage_q      <= '0;
      nf_q         <= '0;
      wait_q       <= '0;
      wd_q         <= '0;
      sink_ready_q <= 1'b1;
      rd_start_q   <= 1'b0;
      wr_start_q   <= 1'b0;
      src_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_sop_q    <= 1'b0;
      err_to_q     <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      stage_q      <= stage_d;
      nf_q         <= nf_d;
      wait_q       <= wait_d;
      wd_q         <= wd_d;
      sink_ready_q <= sink_ready_d;
      rd_start_q   <= rd_start_d;
      wr_start_q   <= wr_start_d;
      src_start_q  <= src_start_d;
      busy_q       <= busy_d;
      err_sop_q    <= err_sop_d;
      err_to_q     <= err_to_d;
    end
  end

  assign bus.fsm           = fsm_q;
  assign bus.current_stage = stage_q;
  assign bus.sink_ready    = sink_ready_q;
  assign bus.rd_start      = rd_start_q;
  assign bus.wr_start      = wr_start_q;
  assign bus.source_start  = src_start_q;
  assign bus.busy          = busy_q;
  assign bus.err_sop       = err_sop_q;
  assign bus.err_timeout   = err_to_q;

endmodule

// File: tb/tb_mrd_stage_sched.sv
// Directed bench for mrd_stage_sched: PARAM_WAIT=8, TIMEOUT=64, STG_W=3.
module tb_mrd_stage_sched;
  localparam int STG_W = 3;
  localparam logic [2:0] F_IDLE = 3'd0, F_SINK = 3'd1, F_PARAM = 3'd2,
                         F_RD = 3'd3, F_WR = 3'd4, F_SRC = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mrd_stage_sched_if #(.STG_W(STG_W)) bus_if ();

  mrd_stage_sched #(.PARAM_WAIT(8), .TIMEOUT(64), .STG_W(STG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int vectors = 0;
  int miscompares = 0;
  int last_st = 0;
  int n_rd = 0, n_wr = 0, n_src = 0;
  int r0, w0, s0;

  always @(negedge clk) begin
    if (bus_if.rd_start)     n_rd  <= n_rd + 1;
    if (bus_if.wr_start)     n_wr  <= n_wr + 1;
    if (bus_if.source_start) n_src <= n_src + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output vector; sink_ready and busy follow from the expected state.
  task automatic chk(input string tag, input logic [2:0] f, input int st,
                     input logic rs, input logic ws, input logic ss,
                     input logic es, input logic et);
    logic [12:0] obs, exp;
    obs = {bus_if.fsm, bus_if.current_stage, bus_if.sink_ready, bus_if.rd_start,
           bus_if.wr_start, bus_if.source_start, bus_if.busy, bus_if.err_sop,
           bus_if.err_timeout};
    exp = {f, 3'(st), (f <= 3'd1), rs, ws, ss, (f != 3'd0), es, et};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    r0 = n_rd; w0 = n_wr; s0 = n_src;
  endtask

  task automatic send_frame(input int len, input int nf);
    bus_if.num_factors = 3'(nf);
    bus_if.sink_sop = 1'b1;
    if (len == 1) bus_if.sink_eop = 1'b1;
    tick();
    bus_if.sink_sop = 1'b0;
    bus_if.sink_eop = 1'b0;
    if (len > 1) begin
      chk("sink_mid", F_SINK, last_st, 0, 0, 0, 0, 0);
      repeat (len - 2) tick();
      bus_if.sink_eop = 1'b1;
      tick();
      bus_if.sink_eop = 1'b0;
    end
  endtask

  // Entered on PARAM cycle 1; leaves on the edge that ends PARAM cycle 8.
  task automatic param_phase();
    chk("param_entry", F_PARAM, last_st, 0, 0, 0, 0, 0);
    repeat (7) tick();
    chk("param_last", F_PARAM, last_st, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic run_stage(input int st, input int nf, input int rd_lat, input int wr_lat);
    chk("rd_entry", F_RD, st, 1, 0, 0, 0, 0);
    if (rd_lat > 1) begin
      repeat (rd_lat - 1) tick();
      chk("rd_hold", F_RD, st, 0, 0, 0, 0, 0);
    end
    bus_if.rd_done = 1'b1;
    tick();
    bus_if.rd_done = 1'b0;
    chk("wr_entry", F_WR, st, 0, 1, 0, 0, 0);
    if (wr_lat > 1) begin
      repeat (wr_lat - 1) tick();
      chk("wr_hold", F_WR, st, 0, 0, 0, 0, 0);
    end
    bus_if.wr_done = 1'b1;
    tick();
    bus_if.wr_done = 1'b0;
    if (st == nf - 1) chk("src_pulse", F_SRC, st, 0, 0, 1, 0, 0);
  endtask

  task automatic run_stages(input int nf);
    for (int st = 0; st < nf; st++) run_stage(st, nf, (st % 3) + 1, (st % 2) + 1);
    tick();
    chk("idle_after", F_IDLE, nf - 1, 0, 0, 0, 0, 0);
    last_st = nf - 1;
  endtask

  initial begin
    bus_if.sink_sop = 1'b0;
    bus_if.sink_eop = 1'b0;
    bus_if.num_factors = '0;
    bus_if.source_ongoing = 1'b0;
    bus_if.rd_done = 1'b0;
    bus_if.wr_done = 1'b0;

    repeat (2) tick();
    chk("reset_state", F_IDLE, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    tick();
    chk("idle_after_reset", F_IDLE, 0, 0, 0, 0, 0, 0);

    // 1: 1200-point frame, five factors
    snap();
    send_frame(1200, 5);
    param_phase();
    run_stages(5);
    chk_n("t1_rd_starts", n_rd - r0, 5);
    chk_n("t1_wr_starts", n_wr - w0, 5);
    chk_n("t1_src_starts", n_src - s0, 1);

    // 2: source still draining stretches PARAM by 20 cycles
    snap();
    bus_if.source_ongoing = 1'b1;
    send_frame(1200, 5);
    param_phase();
    repeat (19) tick();
    chk("param_stall", F_PARAM, last_st, 0, 0, 0, 0, 0);
    chk_n("t2_no_pulse_stall", (n_rd - r0) + (n_wr - w0) + (n_src - s0), 0);
    bus_if.source_ongoing = 1'b0;
    tick();
    run_stages(5);
    chk_n("t2_rd_starts", n_rd - r0, 5);
    chk_n("t2_wr_starts", n_wr - w0, 5);

    // 3: zero factors goes straight to the source
    snap();
    send_frame(4, 0);
    param_phase();
    chk("src_nf0", F_SRC, last_st, 0, 0, 1, 0, 0);
    tick();
    chk("idle_nf0", F_IDLE, last_st, 0, 0, 0, 0, 0);
    chk_n("t3_rd_wr_starts", (n_rd - r0) + (n_wr - w0), 0);
    chk_n("t3_src_starts", n_src - s0, 1);

    // 4: stage 1 read never completes -> watchdog
    send_frame(8, 3);
    param_phase();
    run_stage(0, 3, 2, 1);
    chk("to_rd_entry", F_RD, 1, 1, 0, 0, 0, 0);
    repeat (62) tick();
    chk("to_cycle63", F_RD, 1, 0, 0, 0, 0, 0);
    tick();
    chk("to_pulse", F_RD, 1, 0, 0, 0, 0, 1);
    tick();
    chk("to_idle", F_IDLE, 0, 0, 0, 0, 0, 0);
    last_st = 0;
    snap();
    send_frame(16, 2);
    param_phase();
    run_stages(2);
    chk_n("t4_recover_rd", n_rd - r0, 2);

    // 5: protocol violations in SINK, WR and IDLE
    snap();
    bus_if.num_factors = 3'd3;
    bus_if.sink_sop = 1'b1;
    tick();
    bus_if.sink_sop = 1'b0;
    tick();
    bus_if.sink_sop = 1'b1;
    tick();
    bus_if.sink_sop = 1'b0;
    chk("sop_in_sink", F_SINK, last_st, 0, 0, 0, 1, 0);
    tick();
    chk("sink_err_clear", F_SINK, last_st, 0, 0, 0, 0, 0);
    bus_if.sink_eop = 1'b1;
    tick();
    bus_if.sink_eop = 1'b0;
    param_phase();
    run_stage(0, 3, 1, 1);
    chk("t5_rd1", F_RD, 1, 1, 0, 0, 0, 0);
    bus_if.rd_done = 1'b1;
    tick();
    bus_if.rd_done = 1'b0;
    chk("t5_wr1", F_WR, 1, 0, 1, 0, 0, 0);
    bus_if.sink_sop = 1'b1;
    tick();
    bus_if.sink_sop = 1'b0;
    chk("sop_in_wr", F_WR, 1, 0, 0, 0, 1, 0);
    bus_if.wr_done = 1'b1;
    tick();
    bus_if.wr_done = 1'b0;
    run_stage(2, 3, 1, 1);
    tick();
    chk("t5_idle", F_IDLE, 2, 0, 0, 0, 0, 0);
    last_st = 2;
    chk_n("t5_rd_starts", n_rd - r0, 3);
    chk_n("t5_wr_starts", n_wr - w0, 3);
    bus_if.sink_eop = 1'b1;
    tick();
    bus_if.sink_eop = 1'b0;
    chk("eop_in_idle", F_IDLE, 2, 0, 0, 0, 1, 0);
    tick();
    chk("idle_err_clear", F_IDLE, 2, 0, 0, 0, 0, 0);

    // 6: asynchronous reset in the middle of stage 2 write
    send_frame(6, 4);
    param_phase();
    run_stage(0, 4, 1, 1);
    run_stage(1, 4, 2, 2);
    chk("t6_rd2", F_RD, 2, 1, 0, 0, 0, 0);
    bus_if.rd_done = 1'b1;
    tick();
    bus_if.rd_done = 1'b0;
    chk("t6_wr2", F_WR, 2, 0, 1, 0, 0, 0);
    tick();
    chk("t6_wr2_hold", F_WR, 2, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", F_IDLE, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b0;
    tick();
    chk("post_reset", F_IDLE, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
